// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Elastic pipeline-stage register with valid/ready handshakes on
//               both sides. Carries a payload and an exception vector as one
//               unit. Optional 2-entry skid buffer gives full throughput with
//               a registered in_ready. Flush discards held entries and counts
//               the valid ones in a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int EXC_W  = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic [1:0]        count,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic              w_m_vld;
  logic              w_s_vld;
  logic [DATA_W-1:0] w_m_data;
  logic [EXC_W-1:0]  w_m_exc;
  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_out_fire;

  assign w_in_fire  = in_valid & w_in_ready;
  assign w_out_fire = w_m_vld & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic              r_m_vld;
      logic              r_s_vld;
      logic [DATA_W-1:0] r_m_data;
      logic [DATA_W-1:0] r_s_data;
      logic [EXC_W-1:0]  r_m_exc;
      logic [EXC_W-1:0]  r_s_exc;

      // Main/skid storage: M always holds the oldest entry, S only fills when
      // M is stalled, so in_ready comes straight from a flop.
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          r_m_vld  <= 1'b0;
          r_m_data <= '0;
          r_m_exc  <= '0;
          r_s_vld  <= 1'b0;
          r_s_data <= '0;
          r_s_exc  <= '0;
        end else if (!r_s_vld) begin
          if (w_in_fire && (!r_m_vld || w_out_fire)) begin
            r_m_vld  <= 1'b1;
            r_m_data <= in_data;
            r_m_exc  <= in_exc;
          end else if (w_in_fire) begin
            r_s_vld  <= 1'b1;
            r_s_data <= in_data;
            r_s_exc  <= in_exc;
          end else if (w_out_fire) begin
            r_m_vld  <= 1'b0;
            r_m_data <= '0;
            r_m_exc  <= '0;
          end
        end else if (w_out_fire) begin
          r_m_vld  <= 1'b1;
          r_m_data <= r_s_data;
          r_m_exc  <= r_s_exc;
          r_s_vld  <= 1'b0;
          r_s_data <= '0;
          r_s_exc  <= '0;
        end
      end

      assign w_m_vld    = r_m_vld;
      assign w_s_vld    = r_s_vld;
      assign w_m_data   = r_m_data;
      assign w_m_exc    = r_m_exc;
      assign w_in_ready = ~r_s_vld;
    end else begin : g_noskid
      logic              r_m_vld;
      logic [DATA_W-1:0] r_m_data;
      logic [EXC_W-1:0]  r_m_exc;

      // Single entry: refill in the same cycle the entry drains, clear when
      // it drains without a replacement.
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          r_m_vld  <= 1'b0;
          r_m_data <= '0;
          r_m_exc  <= '0;
        end else if (w_in_fire) begin
          r_m_vld  <= 1'b1;
          r_m_data <= in_data;
          r_m_exc  <= in_exc;
        end else if (w_out_fire) begin
          r_m_vld  <= 1'b0;
          r_m_data <= '0;
          r_m_exc  <= '0;
        end
      end

      assign w_m_vld    = r_m_vld;
      assign w_s_vld    = 1'b0;
      assign w_m_data   = r_m_data;
      assign w_m_exc    = r_m_exc;
      assign w_in_ready = ~r_m_vld | out_ready;
    end
  endgenerate

  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W:0]   w_drop_sum;

  // One extra bit so adding up to two drops cannot wrap before saturation.
  assign w_drop_sum = {1'b0, r_drop_cnt}
                    + {{CNT_W{1'b0}}, w_m_vld}
                    + {{CNT_W{1'b0}}, w_s_vld};

  // Saturating count of valid entries thrown away by flush; reset drops are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (flush && (w_m_vld || w_s_vld)) begin
      if (w_drop_sum > {1'b0, c_cnt_max}) begin
        r_drop_cnt <= c_cnt_max;
      end else begin
        r_drop_cnt <= w_drop_sum[CNT_W-1:0];
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_m_vld;
  assign out_data  = w_m_data;
  assign out_exc   = w_m_exc;
  assign count     = {w_s_vld, w_m_vld & ~w_s_vld};
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg. Three instances
//               (skid, no-skid, skid with 2-bit drop counter) are each
//               compared every cycle against a FIFO model of the stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int DW = 16;
  localparam int EW = 8;

  logic          clk;
  logic          rst;
  logic          flush     [3];
  logic          in_valid  [3];
  logic          in_ready  [3];
  logic [DW-1:0] in_data   [3];
  logic [EW-1:0] in_exc    [3];
  logic          out_valid [3];
  logic          out_ready [3];
  logic [DW-1:0] out_data  [3];
  logic [EW-1:0] out_exc   [3];
  logic [1:0]    count     [3];
  logic [7:0]    dc        [2];
  logic [1:0]    dc2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a bounded FIFO per instance plus a drop tally.
  logic [DW+EW-1:0] m_q [3][2];
  int  m_n    [3];
  int  m_drop [3];
  bit  m_known = 1'b0;
  int  c_max  [3] = '{255, 255, 3};
  bit  c_skid [3] = '{1'b1, 1'b0, 1'b1};

  pipe_stage_reg #(.DATA_W(DW), .EXC_W(EW), .SKID(1), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_exc(in_exc[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_exc(out_exc[0]), .count(count[0]), .drop_cnt(dc[0]));

  pipe_stage_reg #(.DATA_W(DW), .EXC_W(EW), .SKID(0), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_exc(in_exc[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_exc(out_exc[1]), .count(count[1]), .drop_cnt(dc[1]));

  pipe_stage_reg #(.DATA_W(DW), .EXC_W(EW), .SKID(1), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_exc(in_exc[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .out_exc(out_exc[2]), .count(count[2]), .drop_cnt(dc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input bit v, input logic [DW-1:0] d, input bit ordy, input bit fl);
    in_valid[i]  = v;
    in_data[i]   = d;
    in_exc[i]    = EW'($urandom);
    out_ready[i] = ordy;
    flush[i]     = fl;
  endtask

  function automatic bit exp_ready(input int i);
    if (c_skid[i]) return (m_n[i] < 2);
    return (m_n[i] == 0) || out_ready[i];
  endfunction

  // One clock: compare outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    bit               rdy [3];
    logic [DW+EW-1:0] head;
    logic [7:0]       obs_drop;
    bit               ofire;
    bit               ifire;
    #1;
    for (int i = 0; i < 3; i++) begin
      rdy[i] = exp_ready(i);
      head   = (m_n[i] > 0) ? m_q[i][0] : '0;
      if (i == 2) obs_drop = {6'b0, dc2};
      else        obs_drop = dc[i[0]];
      if (m_known) begin
        check($sformatf("d%0d in_ready", i),  32'(in_ready[i]),  32'(rdy[i]));
        check($sformatf("d%0d out_valid", i), 32'(out_valid[i]), 32'(m_n[i] > 0));
        check($sformatf("d%0d out_data", i),  32'(out_data[i]),  32'(head[DW-1:0]));
        check($sformatf("d%0d out_exc", i),   32'(out_exc[i]),   32'(head[DW+EW-1:DW]));
        check($sformatf("d%0d count", i),     32'(count[i]),     32'(m_n[i]));
        check($sformatf("d%0d drop_cnt", i),  32'(obs_drop),     32'(m_drop[i]));
      end
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_n[i]    = 0;
        m_drop[i] = 0;
      end else if (flush[i]) begin
        m_drop[i] = (m_drop[i] + m_n[i] > c_max[i]) ? c_max[i] : m_drop[i] + m_n[i];
        m_n[i]    = 0;
      end else begin
        ofire = (m_n[i] > 0) && out_ready[i];
        ifire = in_valid[i] && rdy[i];
        if (ofire) begin
          m_q[i][0] = m_q[i][1];
          m_n[i]--;
        end
        if (ifire) begin
          if (m_n[i] < 2) m_q[i][m_n[i]] = {in_exc[i], in_data[i]};
          m_n[i]++;
        end
      end
    end
    if (rst) m_known = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_n[i] = 0;
      m_drop[i] = 0;
      m_q[i][0] = '0;
      m_q[i][1] = '0;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 1'b1, DW'($urandom), 1'b1, 1'b0);
    @(negedge clk);

    // Reset held two cycles with traffic offered.
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, '0, 1'b1, 1'b0);
    step();

    // Back-to-back streaming through the skid stage.
    for (int k = 0; k < 8; k++) begin
      drive(0, 1'b1, DW'(16'h10 + k), 1'b1, 1'b0);
      step();
    end
    drive(0, 1'b0, '0, 1'b1, 1'b0);
    step();
    step();

    // Back-pressure: fill to two, third entry waits upstream, then drain.
    drive(0, 1'b1, 16'hA1, 1'b0, 1'b0); step();
    drive(0, 1'b1, 16'hA2, 1'b0, 1'b0); step();
    drive(0, 1'b1, 16'hA3, 1'b0, 1'b0); step();
    step();
    drive(0, 1'b1, 16'hA3, 1'b1, 1'b0); step();
    step();
    drive(0, 1'b0, '0, 1'b1, 1'b0);
    step(); step(); step();

    // Flush while full with a new entry offered the same cycle.
    drive(0, 1'b1, 16'hB1, 1'b0, 1'b0); step();
    drive(0, 1'b1, 16'hB2, 1'b0, 1'b0); step();
    drive(0, 1'b1, 16'hB3, 1'b0, 1'b1); step();
    drive(0, 1'b0, '0, 1'b1, 1'b0); step(); step();

    // Drop counter saturation on the 2-bit instance.
    for (int r = 0; r < 3; r++) begin
      drive(2, 1'b1, DW'(16'hD0 + 2 * r), 1'b0, 1'b0); step();
      drive(2, 1'b1, DW'(16'hD1 + 2 * r), 1'b0, 1'b0); step();
      drive(2, 1'b0, '0, 1'b0, 1'b1); step();
      drive(2, 1'b0, '0, 1'b0, 1'b0); step();
    end

    // No-skid stage with out_ready toggling under continuous input.
    for (int k = 0; k < 9; k++) begin
      drive(1, 1'b1, DW'(16'hC0 + k), (k % 3) != 1, 1'b0);
      step();
    end
    drive(1, 1'b0, '0, 1'b1, 1'b0);
    step(); step();

    // Random traffic on all instances, with occasional flush and reset.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < 3; i++)
        drive(i, $urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0,
              $urandom_range(0, 15) == 0);
      step();
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, '0, 1'b1, 1'b0);
    step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
